sw_debounce: RTL and testbench

Input conditioning stage placed directly upstream of the counter/shift-register LED datapath. Synchronises the asynchronous board switches into the `clock` domain, rejects contact bounce with a per-bit stability counter, and presents clean, registered switch levels (`o_sw`) that drive the counter's rate-select `i_sw` and the colour-select bit. Also flags every accepted level change so downstream logic or the ILA can trigger on it.

---
 rtl/sw_debounce_pkg.sv | 10 +
 rtl/sw_debounce_bit.sv | 84 ++++++++
 rtl/sw_debounce.sv | 40 ++++
 tb/tb_sw_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults for the switch debouncer.
// N_STABLE_SIM is a short stability window so benches settle in a few cycles.
package sw_debounce_pkg;

    localparam int NB_SW_DEF       = 4;
    localparam int NB_DEBOUNCE_DEF = 16;
    localparam int N_STABLE_DEF    = 50000;
    localparam int N_STABLE_SIM    = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// debounce_bit: conditions one switch bit.
// Two-flop synchroniser, stability counter, accepted level and its previous
// value. Edge outputs exist only when SW_DEBOUNCE_EDGE_EN is defined;
// otherwise they are tied low.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// STABLE    | synchronised level equals accepted level, counter held at 0
// COUNTING  | levels differ, counter runs toward N_STABLE-1, then accepts
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int NB_DEBOUNCE = NB_DEBOUNCE_DEF,
    parameter int N_STABLE    = N_STABLE_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sw_raw,
    output logic level,
    output logic changed,
    output logic rise,
    output logic fall
);

    localparam logic [NB_DEBOUNCE-1:0] CNT_TERM = NB_DEBOUNCE'(N_STABLE - 1);

    logic                   s1;
    logic                   s2;
    logic [NB_DEBOUNCE-1:0] cnt;
    logic                   prev_level;
    logic                   differ;
    logic                   accept;

    assign differ = (s2 != level);
    assign accept = differ && (cnt == CNT_TERM);

    // Bring the raw switch into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Count consecutive differing cycles; any agreement or an accept restarts at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!differ || accept) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + NB_DEBOUNCE'(1);
        end
    end

    // Accepted level plus a one-cycle-delayed copy used to form the pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level      <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            if (accept) begin
                level <= s2;
            end
            prev_level <= level;
        end
    end

    // Both operands are flops, so the pulse is high exactly in the cycle the
    // new level is first visible and has no path from sw_raw.
    assign changed = level ^ prev_level;

`ifdef SW_DEBOUNCE_EDGE_EN
    assign rise = level & ~prev_level;
    assign fall = ~level & prev_level;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounces NB_SW board switches independently.
// One debounce_bit per switch; per-bit change flags are merged into a single
// o_changed pulse. Optional per-bit rise/fall pulses: SW_DEBOUNCE_EDGE_EN.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW       = NB_SW_DEF,
    parameter int NB_DEBOUNCE = NB_DEBOUNCE_DEF,
    parameter int N_STABLE    = N_STABLE_DEF
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic             o_changed,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall
);

    logic [NB_SW-1:0] changed_vec;

    for (genvar i = 0; i < NB_SW; i++) begin : g_bit
        debounce_bit #(
            .NB_DEBOUNCE (NB_DEBOUNCE),
            .N_STABLE    (N_STABLE)
        ) u_bit (
            .clock   (clock),
            .reset_n (i_reset),
            .sw_raw  (i_sw[i]),
            .level   (o_sw[i]),
            .changed (changed_vec[i]),
            .rise    (o_rise[i]),
            .fall    (o_fall[i])
        );
    end

    // Several bits accepting together still yield one pulse.
    assign o_changed = |changed_vec;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: vector table plus scoreboard for sw_debounce (N_STABLE = 4).
// Build with or without SW_DEBOUNCE_EDGE_EN; rise/fall expectations follow it.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_sw = 4'h0;
    logic [3:0] o_sw;
    logic       o_changed;
    logic [3:0] o_rise;
    logic [3:0] o_fall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp_sw;
        logic       exp_ch;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    sw_debounce #(
        .NB_SW       (4),
        .NB_DEBOUNCE (16),
        .N_STABLE    (N_STABLE_SIM)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_sw      (i_sw),
        .o_sw      (o_sw),
        .o_changed (o_changed),
        .o_rise    (o_rise),
        .o_fall    (o_fall)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required summary before it");
        $fatal(1, "timeout");
    end

    task automatic chk4(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] sw, input logic [3:0] exp_sw,
                       input logic ch, input logic [3:0] r, input logic [3:0] f);
        vec_t v;
        v.sw = sw; v.exp_sw = exp_sw; v.exp_ch = ch; v.exp_rise = r; v.exp_fall = f;
        repeat (n) vecs.push_back(v);
    endtask

    // Drive at the falling edge, expect the result one rising edge later.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clock);
        i_sw = v.sw;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk4("o_sw", idx, o_sw, e.exp_sw);
        chk1("o_changed", idx, o_changed, e.exp_ch);
        chk4("o_rise", idx, o_rise, EDGE_EN ? e.exp_rise : 4'h0);
        chk4("o_fall", idx, o_fall, EDGE_EN ? e.exp_fall : 4'h0);
    endtask

    initial begin
        vec_t v;

        // Clean step on bit 0, then back to 0.
        add(5, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 1'b1, 4'h1, 4'h0);
        add(1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0);
        add(5, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h1);
        add(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        // Bounce on bit 1: 1,0,1,0,1 then hold; accept 5 edges after last edge.
        add(1, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        add(5, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h2, 1'b1, 4'h2, 4'h0);
        add(1, 4'h2, 4'h2, 1'b0, 4'h0, 4'h0);
        add(5, 4'h0, 4'h2, 1'b0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h2);
        add(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        // Short glitch on bit 2: 3 cycles is one short of acceptance.
        add(3, 4'h4, 4'h0, 1'b0, 4'h0, 4'h0);
        add(7, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        // Simultaneous 0 -> 9 -> 0.
        add(5, 4'h9, 4'h0, 1'b0, 4'h0, 4'h0);
        add(1, 4'h9, 4'h9, 1'b1, 4'h9, 4'h0);
        add(1, 4'h9, 4'h9, 1'b0, 4'h0, 4'h0);
        add(5, 4'h0, 4'h9, 1'b0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h9);
        add(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

        // Reset state after a couple of edges in reset.
        i_sw = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        chk4("rst_o_sw", 0, o_sw, 4'h0);
        chk1("rst_o_changed", 0, o_changed, 1'b0);
        chk4("rst_o_rise", 0, o_rise, 4'h0);
        chk4("rst_o_fall", 0, o_fall, 4'h0);
        @(negedge clock);
        i_reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Reset mid-run with all switches high.
        v.sw = 4'hF; v.exp_sw = 4'h0; v.exp_ch = 1'b0; v.exp_rise = 4'h0; v.exp_fall = 4'h0;
        for (int i = 0; i < 5; i++) step(v, 100 + i);
        v.exp_sw = 4'hF; v.exp_ch = 1'b1; v.exp_rise = 4'hF;
        step(v, 105);
        v.exp_ch = 1'b0; v.exp_rise = 4'h0;
        step(v, 106);

        @(negedge clock);
        i_reset = 1'b0;
        #1;
        chk4("async_rst_o_sw", 0, o_sw, 4'h0);
        chk1("async_rst_o_changed", 0, o_changed, 1'b0);
        @(posedge clock);
        #1;
        chk4("held_rst_o_sw", 0, o_sw, 4'h0);
        @(posedge clock);
        #2;
        i_reset = 1'b1;

        // First post-release edge is row 200; o_sw follows 5 edges later.
        v.exp_sw = 4'h0; v.exp_ch = 1'b0; v.exp_rise = 4'h0; v.exp_fall = 4'h0;
        for (int i = 0; i < 5; i++) step(v, 200 + i);
        v.exp_sw = 4'hF; v.exp_ch = 1'b1; v.exp_rise = 4'hF;
        step(v, 205);
        v.exp_ch = 1'b0; v.exp_rise = 4'h0;
        step(v, 206);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
